// File: rtl/parity_pkg.sv
// Shared constants for the stripe parity generator / rebuild pair.
package parity_pkg;
  localparam int   WORD_WIDTH   = 64;
  localparam int   N_LANES      = 16;
  localparam logic MODE_CHECK   = 1'b0;
  localparam logic MODE_REBUILD = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/parity_rebuild.sv
// XOR-accumulates one stripe of lane words plus parity; yields the syndrome
// (check mode) or the missing lane word (rebuild mode).
module parity_rebuild #(
  parameter int WORD_WIDTH = 64,
  parameter int N_LANES    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  busy
);
  import parity_pkg::*;

  localparam int CNT_W = $clog2(N_LANES + 2);

  state_t                state_reg, state_next;
  logic [WORD_WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  mode_reg, mode_next;
  logic [WORD_WIDTH-1:0] out_data_reg, out_data_next;
  logic                  out_err_reg, out_err_next;
  logic                  out_valid_reg, out_valid_next;

  logic [WORD_WIDTH-1:0] acc_beat;
  logic [CNT_W-1:0]      last_cnt;

  // Check mode carries one extra beat: the stored parity word.
  assign last_cnt = (mode_reg == MODE_CHECK) ? CNT_W'(N_LANES) : CNT_W'(N_LANES - 1);
  assign acc_beat = acc_reg ^ in_data;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    mode_next      = mode_reg;
    out_data_next  = out_data_reg;
    out_err_next   = out_err_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next  = mode;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_next = acc_beat;
          if (cnt_reg == last_cnt) begin
            cnt_next       = '0;
            state_next     = DONE;
            out_data_next  = acc_beat;
            out_err_next   = (mode_reg == MODE_CHECK) && (|acc_beat);
            out_valid_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      out_data_reg  <= '0;
      out_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      mode_reg      <= mode_next;
      out_data_reg  <= out_data_next;
      out_err_reg   <= out_err_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign in_ready  = (state_reg == ACCUM);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_err   = out_err_reg;
endmodule
